// File: rtl/mbox_pkg.sv
// Shared types and constants for the mailbox message framer.
package mbox_pkg;

    // Framer control states.
    typedef enum logic [1:0] {
        StIdle,
        StPayload,
        StDrop
    } state_e;

    // Low 16 bits of a header word.
    typedef struct packed {
        logic [7:0] id;
        logic [7:0] len;
    } hdr_t;

    localparam int unsigned HDR_LEN_LSB = 0;
    localparam int unsigned HDR_ID_LSB  = 8;
    localparam int unsigned MSG_CNT_W   = 16;

endpackage

// File: rtl/mbox_out_reg.sv
// Single-entry valid/ready output register carrying data plus sop/eop markers.
module mbox_out_reg #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_sop,
    input  logic                  load_eop,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop
);

    // Load a new word, or drop valid once the current word has been taken.
    // The caller only loads when the slot is empty or being drained this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_sop   <= load_sop;
            out_eop   <= load_eop;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mbox_msg_framer.sv
// Mailbox message framer: parses header length, tags sop/eop, drops oversized
// messages. Optional payload stall timeout enabled by MBOX_FRAMER_TIMEOUT_EN.
module mbox_msg_framer
    import mbox_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_sop_o,
    output logic                  out_eop_o,
    output logic                  err_len_o,
    output logic                  err_timeout_o,
    output logic [15:0]           msg_cnt_o
);

    localparam logic [7:0] MaxLen = 8'(MAX_LEN);

    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   err_len_q, err_len_d;
    logic [MSG_CNT_W-1:0]   msg_cnt_q;
    logic                   accept;
    logic                   fwd, fwd_sop, fwd_eop;
    logic                   timeout_hit;
    hdr_t                   hdr;

    // DROP swallows words regardless of the output slot.
    always_comb begin
        if (rst) begin
            in_ready_o = 1'b0;
        end else if (state_q == StDrop) begin
            in_ready_o = 1'b1;
        end else begin
            in_ready_o = !out_valid_o || out_ready_i;
        end
        accept = in_valid_i && in_ready_o;
        hdr    = hdr_t'(in_data_i[HDR_ID_LSB+7:HDR_LEN_LSB]);
    end

    // Next-state, counter, forward and error decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_len_d = 1'b0;
        fwd       = 1'b0;
        fwd_sop   = 1'b0;
        fwd_eop   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (hdr.len == 8'd0) begin
                        fwd     = 1'b1;
                        fwd_sop = 1'b1;
                        fwd_eop = 1'b1;
                    end else if (hdr.len <= MaxLen) begin
                        fwd     = 1'b1;
                        fwd_sop = 1'b1;
                        cnt_d   = hdr.len;
                        state_d = StPayload;
                    end else begin
                        err_len_d = 1'b1;
                        cnt_d     = hdr.len;
                        state_d   = StDrop;
                    end
                end
            end
            StPayload: begin
                if (accept) begin
                    fwd     = 1'b1;
                    fwd_eop = (cnt_q == 8'd1);
                    cnt_d   = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = StIdle;
                end
            end
            StDrop: begin
                if (accept) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A stalled message is abandoned without eop.
        if (timeout_hit) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    // FSM, counter and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_len_q <= err_len_d;
        end
    end

    // Completed-message counter, bumped on the eop output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_cnt_q <= '0;
        end else if (out_valid_o && out_ready_i && out_eop_o) begin
            msg_cnt_q <= msg_cnt_q + 16'd1;
        end
    end

    assign err_len_o = err_len_q;
    assign msg_cnt_o = msg_cnt_q;

`ifdef MBOX_FRAMER_TIMEOUT_EN
    logic [31:0] stall_q;
    logic        err_timeout_q;

    // Fires on the cycle that completes TIMEOUT_CYCLES idle cycles mid-message.
    always_comb begin
        timeout_hit = (state_q != StIdle) && !accept &&
                      ((stall_q + 32'd1) == 32'(TIMEOUT_CYCLES));
    end

    // Stall counter and timeout pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q       <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            err_timeout_q <= timeout_hit;
            if (state_q == StIdle || accept || timeout_hit) begin
                stall_q <= '0;
            end else begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign err_timeout_o = err_timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

    mbox_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (fwd),
        .load_data  (in_data_i),
        .load_sop   (fwd_sop),
        .load_eop   (fwd_eop),
        .out_ready  (out_ready_i),
        .out_valid  (out_valid_o),
        .out_data   (out_data_o),
        .out_sop    (out_sop_o),
        .out_eop    (out_eop_o)
    );

endmodule

// File: tb/tb_mbox_msg_framer.sv
// Self-checking bench for mbox_msg_framer: message table plus corner sequences.
module tb_mbox_msg_framer;

    localparam int DW = 32;
    localparam int ML = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready_o;
    logic [DW-1:0] in_data;
    logic          out_valid_o;
    logic          out_ready;
    logic [DW-1:0] out_data_o;
    logic          out_sop_o;
    logic          out_eop_o;
    logic          err_len_o;
    logic          err_timeout_o;
    logic [15:0]   msg_cnt_o;

    mbox_msg_framer #(
        .DATA_WIDTH     (DW),
        .MAX_LEN        (ML),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready_o),
        .in_data_i     (in_data),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data_o),
        .out_sop_o     (out_sop_o),
        .out_eop_o     (out_eop_o),
        .err_len_o     (err_len_o),
        .err_timeout_o (err_timeout_o),
        .msg_cnt_o     (msg_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } word_t;

    typedef struct {
        int len;
        int id;
        int rmode;      // 0: ready always high, 1: ready 1,0,0 repeating
        int exp_words;
        int exp_err;
        int exp_msgs;
    } vec_t;

    word_t sb[$];
    int    checks = 0;
    int    failures = 0;

    // Reference model state
    int          m_state = 0;   // 0 idle, 1 payload, 2 drop
    int          m_cnt = 0;
    int          m_stall = 0;
    logic        m_ov = 1'b0;
    logic        m_err = 1'b0;
    logic        m_to = 1'b0;
    logic [15:0] m_msg = '0;

    int    n_words = 0;
    int    n_err = 0;
    int    n_to = 0;
    int    cyc_no = 0;
    logic  hold_valid = 1'b0;
    word_t hold_w;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, sample at negedge, advance model, step clock.
    task automatic cyc(input logic v, input logic [31:0] d, input logic r, output logic acc);
        logic  m_ready;
        logic  fwd;
        int    ps;
        int    len;
        word_t got;
        word_t cur;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
        m_ready = (m_state == 2) ? 1'b1 : (!m_ov || r);
        chk("in_ready", in_ready_o, m_ready);
        chk("out_valid", out_valid_o, m_ov);
        chk("err_len", err_len_o, m_err);
        chk("err_timeout", err_timeout_o, m_to);
        chk("msg_cnt", msg_cnt_o, m_msg);
        if (err_len_o) n_err++;
        if (err_timeout_o) n_to++;
        cur = {out_data_o, out_sop_o, out_eop_o};
        if (hold_valid && out_valid_o) chk("hold_stable", cur, hold_w);
        hold_valid = out_valid_o && !r;
        hold_w     = cur;
        if (out_valid_o && r) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                got = sb.pop_front();
                chk("out_word", cur, got);
                n_words++;
                if (got.eop) m_msg = m_msg + 16'd1;
            end
        end
        acc   = v && m_ready;
        fwd   = 1'b0;
        m_err = 1'b0;
        m_to  = 1'b0;
        ps    = m_state;
        if (acc) begin
            case (m_state)
                0: begin
                    len = int'(d[7:0]);
                    if (len == 0) begin
                        sb.push_back({d, 1'b1, 1'b1});
                        fwd = 1'b1;
                    end else if (len <= ML) begin
                        sb.push_back({d, 1'b1, 1'b0});
                        fwd     = 1'b1;
                        m_cnt   = len;
                        m_state = 1;
                    end else begin
                        m_err   = 1'b1;
                        m_cnt   = len;
                        m_state = 2;
                    end
                end
                1: begin
                    sb.push_back({d, 1'b0, (m_cnt == 1)});
                    fwd = 1'b1;
                    if (m_cnt == 1) m_state = 0;
                    m_cnt--;
                end
                default: begin
                    if (m_cnt == 1) m_state = 0;
                    m_cnt--;
                end
            endcase
        end
`ifdef MBOX_FRAMER_TIMEOUT_EN
        if (ps != 0) begin
            m_stall = acc ? 0 : m_stall + 1;
            if (m_stall == TO) begin
                m_to    = 1'b1;
                m_state = 0;
                m_cnt   = 0;
                m_stall = 0;
            end
        end else begin
            m_stall = 0;
        end
`else
        if (ps < 0) m_stall = 0;
`endif
        m_ov = fwd ? 1'b1 : (r ? 1'b0 : m_ov);
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("in_ready_in_rst", in_ready_o, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_fields", {out_data_o, out_sop_o, out_eop_o}, 0);
        chk("rst_errs", {err_len_o, err_timeout_o}, 0);
        chk("rst_msg_cnt", msg_cnt_o, 0);
        sb.delete();
        m_state = 0; m_cnt = 0; m_stall = 0;
        m_ov = 1'b0; m_err = 1'b0; m_to = 1'b0; m_msg = '0;
        hold_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] hdr_word(input int len, input int id);
        return {8'h5A, 8'hC3, id[7:0], len[7:0]};
    endfunction

    function automatic logic [31:0] pay_word(input int id, input int j);
        return {id[7:0], 24'h0000A1} + 32'(j);
    endfunction

    task automatic send_word(input logic [31:0] w, input int rmode);
        logic acc;
        logic r;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            r = (rmode == 0) ? 1'b1 : ((cyc_no % 3) == 0);
            cyc(1'b1, w, r, acc);
            tries++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain(input int n);
        logic acc;
        repeat (n) cyc(1'b0, '0, 1'b1, acc);
    endtask

    task automatic send_msg(input int len, input int id, input int rmode, input int npay);
        send_word(hdr_word(len, id), rmode);
        for (int j = 0; j < npay; j++) send_word(pay_word(id, j), rmode);
    endtask

    vec_t vt[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        int          w0, e0, t0, k, hit;
        logic [15:0] c0;

        vt[0] = '{3,   8'h11, 0, 4,  0, 1};
        vt[1] = '{0,   8'h22, 0, 1,  0, 1};
        vt[2] = '{20,  8'h33, 0, 0,  1, 0};
        vt[3] = '{1,   8'h44, 0, 2,  0, 1};
        vt[4] = '{4,   8'h55, 1, 5,  0, 1};
        vt[5] = '{16,  8'h66, 1, 17, 0, 1};
        vt[6] = '{17,  8'h77, 0, 0,  1, 0};
        vt[7] = '{255, 8'h88, 0, 0,  1, 0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Table: one message per entry
        for (int i = 0; i < 8; i++) begin
            w0 = n_words; e0 = n_err; c0 = msg_cnt_o;
            send_msg(vt[i].len, vt[i].id, vt[i].rmode, vt[i].len);
            drain(3);
            chk($sformatf("vec%0d_words", i), n_words - w0, vt[i].exp_words);
            chk($sformatf("vec%0d_err", i), n_err - e0, vt[i].exp_err);
            chk($sformatf("vec%0d_msgs", i), msg_cnt_o - c0, vt[i].exp_msgs);
        end

        // Back-to-back messages with no idle gaps
        w0 = n_words;
        send_msg(0, 8'h90, 0, 0);
        send_msg(2, 8'h91, 0, 2);
        send_msg(0, 8'h92, 0, 0);
        drain(3);
        chk("b2b_words", n_words - w0, 5);
        chk("b2b_msg_cnt", msg_cnt_o, 16'd8);

        // Reset mid-message with a held output word
        send_word(hdr_word(5, 8'hA0), 0);
        send_word(pay_word(8'hA0, 0), 0);
        cyc(1'b1, pay_word(8'hA0, 1), 1'b0, acc);
        cyc(1'b1, pay_word(8'hA0, 2), 1'b0, acc);
        chk("held_before_rst", out_valid_o, 1);
        do_reset();
        send_msg(1, 8'hA1, 0, 1);
        drain(3);
        chk("post_rst_msg_cnt", msg_cnt_o, 16'd1);

        // Payload stall
        t0 = n_to; c0 = msg_cnt_o;
        send_word(hdr_word(2, 8'hB0), 0);
        send_word(pay_word(8'hB0, 0), 0);
`ifdef MBOX_FRAMER_TIMEOUT_EN
        hit = 0;
        for (k = 1; k <= 12; k++) begin
            cyc(1'b0, '0, 1'b1, acc);
            if (hit == 0 && n_to != t0) hit = k;
        end
        chk("timeout_delay", hit, 9);
        chk("timeout_pulses", n_to - t0, 1);
        chk("timeout_no_eop", msg_cnt_o - c0, 0);
        w0 = n_words;
        send_msg(0, 8'hB1, 0, 0);
        drain(3);
        chk("after_timeout_words", n_words - w0, 1);
        chk("after_timeout_msgs", msg_cnt_o - c0, 1);
`else
        hit = 0;
        drain(20);
        chk("no_timeout", n_to - t0, hit);
        send_word(pay_word(8'hB0, 1), 0);
        drain(3);
        chk("stall_completes", msg_cnt_o - c0, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
